// File: rtl/vc_test_delay_arb_pkg.sv
// vc_test_delay_arb_pkg: shared state encoding and widths for the vc test arbitration blocks
package vc_test_delay_arb_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;
  localparam int DELAY_W = 32;
endpackage

// File: rtl/vc_rr_arb_pick.sv
// vc_rr_arb_pick: combinational round-robin pick of the first request at or after ptr
module vc_rr_arb_pick #(
  parameter int p_nreqs = 2
) (
  input  logic [p_nreqs-1:0]         i_req,
  input  logic [$clog2(p_nreqs)-1:0] i_ptr,
  output logic [$clog2(p_nreqs)-1:0] o_grant,
  output logic                       o_any
);
  localparam int SW = $clog2(p_nreqs);
  always_comb begin
    o_grant = '0;
    o_any = |i_req;
    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    for (int i = p_nreqs - 1; i >= 0; i--)
      if (i_req[(int'(i_ptr) + i) % p_nreqs]) o_grant = SW'((int'(i_ptr) + i) % p_nreqs);
  end
endmodule

// File: rtl/vc_test_delay_arb.sv
// vc_test_delay_arb: round-robin arbiter sharing one output channel, with a per-grant delay
module vc_test_delay_arb
  import vc_test_delay_arb_pkg::*;
#(
  parameter int p_msg_nbits = 1,
  parameter int p_nreqs     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DELAY_W-1:0]             delay_amt,
  input  logic [p_nreqs-1:0]             in_val,
  output logic [p_nreqs-1:0]             in_rdy,
  input  logic [p_nreqs*p_msg_nbits-1:0] in_msg,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [p_msg_nbits-1:0]         out_msg,
  output logic [$clog2(p_nreqs)-1:0]     out_src
);
  state_e                     r_state;
  logic [DELAY_W-1:0]         r_cnt;
  logic [$clog2(p_nreqs)-1:0] r_grant, r_ptr, w_pick;
  logic                       r_bub, w_any, w_arb, w_zero, w_done, w_xfer;
  vc_rr_arb_pick #(.p_nreqs(p_nreqs)) u_pick (
    .i_req  (in_val),
    .i_ptr  (r_ptr),
    .o_grant(w_pick),
    .o_any  (w_any)
  );
  // r_bub blocks arbitration for the cycle right after any transfer.
  always_comb begin
    w_arb = r_state == IDLE && !r_bub && w_any;
    w_zero = w_arb && delay_amt == '0 && out_rdy;
    w_done = r_state == WAIT && r_cnt == '0;
    out_src = r_state == IDLE ? w_pick : r_grant;
    out_val = reset && (w_zero || (w_done && in_val[r_grant]));
    in_rdy = '0;
    in_rdy[out_src] = reset && (w_zero || (w_done && out_rdy));
    out_msg = out_val ? in_msg[out_src*p_msg_nbits +: p_msg_nbits] : 'x;
    w_xfer = out_val && out_rdy;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_grant <= '0;
      r_ptr <= '0;
      r_bub <= 1'b0;
    end else begin
      r_bub <= w_xfer;
      if (w_xfer) r_ptr <= (int'(out_src) == p_nreqs - 1) ? '0 : out_src + 1'b1;
      if (r_state == IDLE) begin
        if (w_arb && !w_zero) begin
          r_state <= WAIT;
          r_grant <= w_pick;
          r_cnt <= delay_amt != '0 ? delay_amt - 1'b1 : '0;
        end
      end else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      else if (w_xfer) r_state <= IDLE;
    end
  end
  always_ff @(posedge clk)
    if (reset) assert (!$isunknown({delay_amt, in_val, out_rdy, in_rdy, out_val}));
endmodule

// File: tb/tb_vc_test_delay_arb.sv
// tb_vc_test_delay_arb: directed checks of the delayed round-robin arbiter with four requesters
module tb_vc_test_delay_arb;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] delay_amt;
  logic [3:0]  in_val, in_rdy;
  logic [31:0] in_msg;
  logic        out_val, out_rdy;
  logic [7:0]  out_msg;
  logic [1:0]  out_src;
  int vec = 0, miss = 0;
  logic       ev;
  logic [3:0] er;
  int g;

  vc_test_delay_arb #(.p_msg_nbits(8), .p_nreqs(4)) dut (
    .clk(clk), .reset(reset), .delay_amt(delay_amt), .in_val(in_val), .in_rdy(in_rdy),
    .in_msg(in_msg), .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_src(out_src)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic line_trace;
    $display("%b/%b/%h | %b/%b/%h src=%0d", in_val, in_rdy, in_msg, out_val, out_rdy, out_msg, out_src);
  endtask

  task automatic test_reset;
    reset = 1'b0; in_val = 4'b1111; delay_amt = 0; out_rdy = 1'b1;
    in_msg = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    @(negedge clk);
    vec++; if (out_val !== 1'b0) begin miss++; $display("FAIL reset_out_val: got %b want 0", out_val); end
    vec++; if (in_rdy !== 4'b0) begin miss++; $display("FAIL reset_in_rdy: got %b want 0000", in_rdy); end
    tick;
    reset = 1'b1; in_val = 4'b0;
    @(negedge clk);
    vec++; if (out_val !== 1'b0) begin miss++; $display("FAIL idle_out_val: got %b want 0", out_val); end
    vec++; if (in_rdy !== 4'b0) begin miss++; $display("FAIL idle_in_rdy: got %b want 0000", in_rdy); end
    tick;
  endtask

  task automatic test_zero_rr;
    in_val = 4'b0011; delay_amt = 0; out_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ev = (k % 2 == 0); g = (k / 2) % 2;
      er = ev ? 4'(1 << g) : 4'b0;
      vec++; if (out_val !== ev) begin miss++; $display("FAIL rr_out_val[%0d]: got %b want %b", k, out_val, ev); end
      vec++; if (in_rdy !== er) begin miss++; $display("FAIL rr_in_rdy[%0d]: got %b want %b", k, in_rdy, er); end
      if (ev) begin
        vec++; if (out_src !== 2'(g)) begin miss++; $display("FAIL rr_src[%0d]: got %0d want %0d", k, out_src, g); end
        vec++; if (out_msg !== 8'(8'hA0 + 8'h11 * g)) begin miss++; $display("FAIL rr_msg[%0d]: got %h want %h", k, out_msg, 8'(8'hA0 + 8'h11 * g)); end
      end
      tick;
    end
    in_val = 4'b0;
    tick;
  endtask

  task automatic test_delay3;
    in_val = 4'b0010; delay_amt = 3; out_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) in_val = 4'b0011;
      @(negedge clk);
      ev = (c == 3);
      er = ev ? 4'b0010 : 4'b0;
      vec++; if (out_val !== ev) begin miss++; $display("FAIL d3_out_val[%0d]: got %b want %b", c, out_val, ev); end
      vec++; if (in_rdy !== er) begin miss++; $display("FAIL d3_in_rdy[%0d]: got %b want %b", c, in_rdy, er); end
      if (ev) begin
        vec++; if (out_src !== 2'd1) begin miss++; $display("FAIL d3_src: got %0d want 1", out_src); end
        vec++; if (out_msg !== 8'hB1) begin miss++; $display("FAIL d3_msg: got %h want b1", out_msg); end
      end
      tick;
    end
    in_val = 4'b0;
    tick;
  endtask

  task automatic test_backpressure;
    in_val = 4'b0100; delay_amt = 2;
    for (int c = 0; c < 6; c++) begin
      out_rdy = (c >= 4);
      @(negedge clk);
      ev = (c >= 2 && c <= 4);
      er = (c == 4) ? 4'b0100 : 4'b0;
      vec++; if (out_val !== ev) begin miss++; $display("FAIL bp_out_val[%0d]: got %b want %b", c, out_val, ev); end
      vec++; if (in_rdy !== er) begin miss++; $display("FAIL bp_in_rdy[%0d]: got %b want %b", c, in_rdy, er); end
      if (ev) begin
        vec++; if (out_msg !== 8'hC2) begin miss++; $display("FAIL bp_msg[%0d]: got %h want c2", c, out_msg); end
      end
      tick;
    end
    in_val = 4'b0;
    tick;
  endtask

  task automatic test_delay_change;
    in_val = 4'b1000; delay_amt = 5; out_rdy = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) delay_amt = 0;
      @(negedge clk);
      ev = (c == 5);
      vec++; if (out_val !== ev) begin miss++; $display("FAIL dc_out_val[%0d]: got %b want %b", c, out_val, ev); end
      if (ev) begin
        vec++; if (out_src !== 2'd3) begin miss++; $display("FAIL dc_src: got %0d want 3", out_src); end
      end
      tick;
    end
    in_val = 4'b0;
    tick;
  endtask

  task automatic test_rr4;
    in_val = 4'b0100; delay_amt = 0; out_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) in_val = 4'b0101;
      @(negedge clk);
      line_trace();
      ev = (c % 2 == 0);
      g = (c == 2) ? 0 : 2;
      vec++; if (out_val !== ev) begin miss++; $display("FAIL rr4_out_val[%0d]: got %b want %b", c, out_val, ev); end
      if (ev) begin
        vec++; if (out_src !== 2'(g)) begin miss++; $display("FAIL rr4_src[%0d]: got %0d want %0d", c, out_src, g); end
        vec++; if (in_rdy !== 4'(1 << g)) begin miss++; $display("FAIL rr4_in_rdy[%0d]: got %b want %b", c, in_rdy, 4'(1 << g)); end
      end
      tick;
    end
    in_val = 4'b0;
    tick;
  endtask

  task automatic test_reset_mid_wait;
    in_val = 4'b0010; delay_amt = 4; out_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vec++; if (out_val !== 1'b0) begin miss++; $display("FAIL rw_wait_val[%0d]: got %b want 0", c, out_val); end
      if (c < 2) tick;
    end
    reset = 1'b0; delay_amt = 0;
    #1;
    vec++; if (out_val !== 1'b0) begin miss++; $display("FAIL rw_async_val: got %b want 0", out_val); end
    vec++; if (in_rdy !== 4'b0) begin miss++; $display("FAIL rw_async_rdy: got %b want 0000", in_rdy); end
    tick;
    reset = 1'b1; in_val = 4'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vec++; if (out_val !== 1'b0) begin miss++; $display("FAIL rw_stale_val[%0d]: got %b want 0", c, out_val); end
      tick;
    end
    in_val = 4'b1010;
    @(negedge clk);
    vec++; if (out_val !== 1'b1) begin miss++; $display("FAIL rw_post_val: got %b want 1", out_val); end
    vec++; if (out_src !== 2'd1) begin miss++; $display("FAIL rw_post_src: got %0d want 1", out_src); end
    tick;
    in_val = 4'b0;
    tick;
  endtask

  initial begin
    test_reset();
    test_zero_rr();
    test_delay3();
    test_backpressure();
    test_delay_change();
    test_rr4();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
